alu_issue_seq: RTL and testbench

ALU_ISSUE_SEQ -- requirements
Module: alu_issue_seq

---
 rtl/alu_issue_seq.sv | 194 +++++++++++++++++++
 tb/tb_alu_issue_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_seq.sv
// Single-issue RV ALU sequencer: latches one instruction, reads a 32-entry register file,
// drives an external ALU for one cycle and holds the completion record until it is accepted.
module alu_issue_seq #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  input  logic [31:0]           instr,
  output logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] alu_in1,
  output logic [DATA_WIDTH-1:0] alu_in2,
  output logic [3:0]            alu_func3,
  output logic [3:0]            alu_func7,
  input  logic [DATA_WIDTH-1:0] alu_c,
  input  logic                  alu_zero,
  input  logic                  alu_overflow,
  input  logic                  alu_sign,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [4:0]            res_rd,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [3:0]            res_flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [6:0]            OPC_OP  = 7'b0110011;
  localparam logic [6:0]            OPC_IMM = 7'b0010011;
  localparam logic [DATA_WIDTH-1:0] ZERO    = {DATA_WIDTH{1'b0}};

  state_t                  state_r;
  state_t                  state_s;
  logic [31:0]             instr_r;
  logic [DATA_WIDTH-1:0]   regs_r [32];
  logic [DATA_WIDTH-1:0]   alu_in1_r;
  logic [DATA_WIDTH-1:0]   alu_in2_r;
  logic [3:0]              alu_func3_r;
  logic [3:0]              alu_func7_r;
  logic                    illegal_r;
  logic [4:0]              res_rd_r;
  logic [DATA_WIDTH-1:0]   res_data_r;
  logic [3:0]              res_flags_r;

  logic                    accept_s;
  logic                    retire_s;
  logic [DATA_WIDTH-1:0]   rs1_val_s;
  logic [DATA_WIDTH-1:0]   rs2_val_s;
  logic [DATA_WIDTH-1:0]   imm_s;
  logic [DATA_WIDTH-1:0]   dec_in1_s;
  logic [DATA_WIDTH-1:0]   dec_in2_s;
  logic [3:0]              dec_f3_s;
  logic [3:0]              dec_f7_s;
  logic                    dec_illegal_s;

  // Ready is gated by rst_n so it is low for the whole reset cycle and high as soon as reset lifts.
  assign instr_ready = (state_r == IDLE) && rst_n;
  assign res_valid   = (state_r == RESP);
  assign accept_s    = instr_valid && instr_ready;
  assign retire_s    = (state_r == RESP) && res_ready;

  assign alu_in1   = alu_in1_r;
  assign alu_in2   = alu_in2_r;
  assign alu_func3 = alu_func3_r;
  assign alu_func7 = alu_func7_r;
  assign res_rd    = res_rd_r;
  assign res_data  = res_data_r;
  assign res_flags = res_flags_r;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = READ;
        else          state_s = IDLE;
      end
      READ: state_s = EXEC;
      EXEC: state_s = RESP;
      RESP: begin
        if (res_ready) state_s = IDLE;
        else           state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Register-file read ports and immediate extraction
  always_comb begin
    rs1_val_s = ZERO;
    rs2_val_s = ZERO;
    if (instr_r[19:15] != 5'd0) rs1_val_s = regs_r[instr_r[19:15]];
    else                        rs1_val_s = ZERO;
    if (instr_r[24:20] != 5'd0) rs2_val_s = regs_r[instr_r[24:20]];
    else                        rs2_val_s = ZERO;
    imm_s = {{(DATA_WIDTH-12){instr_r[31]}}, instr_r[31:20]};
  end

  // Decode: operands and ALU function of the latched instruction
  always_comb begin
    dec_in1_s     = ZERO;
    dec_in2_s     = ZERO;
    dec_f3_s      = 4'b0000;
    dec_f7_s      = 4'b0000;
    dec_illegal_s = 1'b0;
    case (instr_r[6:0])
      OPC_OP: begin
        dec_in1_s = rs1_val_s;
        dec_in2_s = rs2_val_s;
        dec_f3_s  = {1'b0, instr_r[14:12]};
        // instr[30] only selects sub / sra; on other funct3 codes it is ignored.
        if (instr_r[30] && ((instr_r[14:12] == 3'b000) || (instr_r[14:12] == 3'b101)))
          dec_f7_s = 4'b0100;
        else
          dec_f7_s = 4'b0000;
      end
      OPC_IMM: begin
        dec_in1_s = rs1_val_s;
        dec_in2_s = imm_s;
        dec_f3_s  = {1'b0, instr_r[14:12]};
        // Only srai uses the alternate function; addi with imm bit 10 set must still add.
        if (instr_r[30] && (instr_r[14:12] == 3'b101))
          dec_f7_s = 4'b0100;
        else
          dec_f7_s = 4'b0000;
      end
      default: begin
        dec_illegal_s = 1'b1;
      end
    endcase
  end

  // Instruction latch, ALU operand registers and completion record
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_r     <= 32'd0;
      alu_in1_r   <= ZERO;
      alu_in2_r   <= ZERO;
      alu_func3_r <= 4'b0000;
      alu_func7_r <= 4'b0000;
      illegal_r   <= 1'b0;
      res_rd_r    <= 5'd0;
      res_data_r  <= ZERO;
      res_flags_r <= 4'b0000;
    end else begin
      if (accept_s) begin
        instr_r <= instr;
      end
      if (state_r == READ) begin
        alu_in1_r   <= dec_in1_s;
        alu_in2_r   <= dec_in2_s;
        alu_func3_r <= dec_f3_s;
        alu_func7_r <= dec_f7_s;
        illegal_r   <= dec_illegal_s;
      end
      if (state_r == EXEC) begin
        res_rd_r <= instr_r[11:7];
        if (illegal_r) begin
          res_data_r  <= ZERO;
          res_flags_r <= 4'b1000;
        end else begin
          res_data_r  <= alu_c;
          res_flags_r <= {1'b0, alu_sign, alu_overflow, alu_zero};
        end
      end
    end
  end

  // Register file: written only when the completion record is accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= ZERO;
      end
    end else if (retire_s && (res_rd_r != 5'd0) && !res_flags_r[3]) begin
      regs_r[res_rd_r] <= res_data_r;
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Scoreboard bench for alu_issue_seq: behavioural external ALU, golden RV model of the
// register file, expected records queued at issue and compared at the response handshake.
module tb_alu_issue_seq;

  localparam int DW = 64;

  typedef struct packed {
    logic [4:0]    rd;
    logic [DW-1:0] data;
    logic [3:0]    flags;
    logic          wb;
  } res_t;

  typedef struct packed {
    logic [DW-1:0] in1;
    logic [DW-1:0] in2;
    logic [3:0]    f3;
    logic [3:0]    f7;
  } op_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid;
  logic [31:0]   instr;
  logic          instr_ready;
  logic [DW-1:0] alu_in1, alu_in2, alu_c, res_data;
  logic [3:0]    alu_func3, alu_func7, res_flags;
  logic          alu_zero, alu_overflow, alu_sign;
  logic          res_valid, res_ready;
  logic [4:0]    res_rd;

  int            n_run  = 0;
  int            n_fail = 0;
  logic [DW-1:0] mreg [32];
  res_t          sbq [$];
  op_t           obs_op;
  logic [DW-1:0] obs_data;
  logic [3:0]    obs_flags;
  logic [5:0]    sh;

  always #5 clk = ~clk;

  alu_issue_seq #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_func3(alu_func3), .alu_func7(alu_func7), .alu_c(alu_c),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_sign(alu_sign),
    .res_valid(res_valid), .res_ready(res_ready), .res_rd(res_rd),
    .res_data(res_data), .res_flags(res_flags)
  );

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_alu(input logic [2:0] f3, input logic alt,
                                  input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  output logic [DW-1:0] c, output logic ovf);
    c   = '0;
    ovf = 1'b0;
    case (f3)
      3'd0: begin
        if (alt) begin
          c   = a - b;
          ovf = (a[DW-1] != b[DW-1]) && (c[DW-1] != a[DW-1]);
        end else begin
          c   = a + b;
          ovf = (a[DW-1] == b[DW-1]) && (c[DW-1] != a[DW-1]);
        end
      end
      3'd1: c = a << b[5:0];
      3'd2: c = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      3'd3: c = (a < b) ? 64'd1 : 64'd0;
      3'd4: c = a ^ b;
      3'd5: c = alt ? DW'($signed(a) >>> b[5:0]) : (a >> b[5:0]);
      3'd6: c = a | b;
      default: c = a & b;
    endcase
  endfunction

  // External ALU model
  always_comb begin
    sh = alu_in2[5:0];
    ref_alu(alu_func3[2:0], alu_func7[2], alu_in1, alu_in2, alu_c, alu_overflow);
    alu_zero = (alu_c == 64'd0);
    alu_sign = alu_c[DW-1];
  end

  function automatic void golden(input logic [31:0] ins, output res_t r, output op_t o);
    logic [DW-1:0] a, b, c;
    logic          ovf, alt, legal;
    logic [2:0]    f3;
    f3    = ins[14:12];
    a     = mreg[ins[19:15]];
    b     = '0;
    alt   = 1'b0;
    legal = 1'b1;
    if (ins[6:0] == 7'b0110011) begin
      b   = mreg[ins[24:20]];
      alt = ins[30];
    end else if (ins[6:0] == 7'b0010011) begin
      b   = {{52{ins[31]}}, ins[31:20]};
      alt = ins[30] && (f3 == 3'd5);
    end else begin
      legal = 1'b0;
    end
    ref_alu(f3, alt, a, b, c, ovf);
    if (legal) begin
      o.in1   = a;
      o.in2   = b;
      o.f3    = {1'b0, f3};
      o.f7    = (alt && (f3 == 3'd0 || f3 == 3'd5)) ? 4'b0100 : 4'b0000;
      r.rd    = ins[11:7];
      r.data  = c;
      r.flags = {1'b0, c[DW-1], ovf, (c == 64'd0)};
      r.wb    = (ins[11:7] != 5'd0);
    end else begin
      o       = '0;
      r.rd    = ins[11:7];
      r.data  = '0;
      r.flags = 4'b1000;
      r.wb    = 1'b0;
    end
  endfunction

  task automatic issue(input logic [31:0] ins, input int stall);
    res_t          er;
    op_t           eo;
    int            cnt;
    logic [DW-1:0] d0;
    cnt = 0;
    while (!instr_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("issue_ready", instr_ready, 1);
    golden(ins, er, eo);
    sbq.push_back(er);
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr = 32'h00100093;
    cnt   = 1;
    while (!res_valid && cnt < 12) begin
      @(negedge clk);
      cnt++;
      if (cnt == 2) obs_op = {alu_in1, alu_in2, alu_func3, alu_func7};
    end
    check_eq("latency", cnt, 3);
    check_eq("alu_in1", obs_op.in1, eo.in1);
    check_eq("alu_in2", obs_op.in2, eo.in2);
    check_eq("alu_func3", obs_op.f3, eo.f3);
    check_eq("alu_func7", obs_op.f7, eo.f7);
    d0 = res_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq("hold_valid", res_valid, 1);
      check_eq("hold_data", res_data, d0);
      check_eq("busy_ready", instr_ready, 0);
    end
    res_ready   = 1'b1;
    instr_valid = 1'b0;
    er = sbq.pop_front();
    check_eq("res_valid", res_valid, 1);
    check_eq("res_rd", res_rd, er.rd);
    check_eq("res_data", res_data, er.data);
    check_eq("res_flags", res_flags, er.flags);
    obs_data  = res_data;
    obs_flags = res_flags;
    @(posedge clk);
    if (er.wb) mreg[er.rd] = er.data;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'd0;
    res_ready   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("rst_res_valid", res_valid, 0);
      check_eq("rst_ready", instr_ready, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", instr_ready, 1);
    check_eq("post_rst_alu_in1", alu_in1, 0);
    check_eq("post_rst_res_data", res_data, 0);
    check_eq("post_rst_res_flags", res_flags, 0);

    // Every register reads zero after reset: add x0, xk, xk
    for (int k = 1; k < 32; k++) begin
      logic [4:0] r;
      r = 5'(k);
      issue({7'b0, r, r, 3'b000, 5'd0, 7'b0110011}, 0);
    end

    issue(32'h00500093, 0);                 // addi x1,x0,5
    check_eq("addi_data", obs_data, 64'd5);
    issue(32'h00700113, 0);                 // addi x2,x0,7
    issue(32'h402081B3, 0);                 // sub x3,x1,x2
    check_eq("sub_f7", obs_op.f7, 4'b0100);
    check_eq("sub_data", obs_data, 64'hFFFF_FFFF_FFFF_FFFE);
    check_eq("sub_sign", obs_flags[2], 1);
    issue(32'h4011D213, 0);                 // srai x4,x3,1
    check_eq("srai_in2", obs_op.in2, 64'h401);
    check_eq("srai_data", obs_data, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(32'h00900013, 5);                 // addi x0,x0,9 with stalled consumer
    check_eq("x0_res_data", obs_data, 64'd9);
    issue(32'h00000033, 0);                 // add x0,x0,x0: x0 still zero
    check_eq("x0_reads_zero", obs_op.in1, 0);
    issue(32'hC0008313, 0);                 // addi x6,x1,-1024 (bit30 set, still add)
    check_eq("addi_neg_f7", obs_op.f7, 4'b0000);
    issue(32'h002083B3, 0);                 // add x7,x1,x2
    issue(32'h4011D433, 0);                 // sra x8,x3,x1
    issue(32'h0011B4B3, 0);                 // sltu x9,x3,x1
    issue(32'h4020E533, 2);                 // or x10,x1,x2 with bit30 set
    issue(32'h000385B3, 0);                 // add x11,x7,x0: reads writeback of x7
    check_eq("raw_x7", obs_op.in1, 64'd12);
    issue(32'h0000006F, 0);                 // jal: illegal
    check_eq("jal_flags", obs_flags, 4'b1000);
    check_eq("jal_data", obs_data, 0);

    // Reset during EXEC of addi x5,x0,1 aborts it
    instr       = 32'h00100293;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_res_valid", res_valid, 0);
    check_eq("abort_ready", instr_ready, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("abort_no_valid", res_valid, 0);
    end
    issue(32'h00028033, 0);                 // add x0,x5,x0
    check_eq("abort_x5", obs_op.in1, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
